// File: rtl/pwm_multi_pkg.sv
// Shared register map, control-bit layout and control register type for the
// multi-channel PWM core.
package pwm_multi_pkg;

    localparam logic [4:0] DVSR_ADDR = 5'h00;
    localparam logic [4:0] CTRL_ADDR = 5'h01;
    localparam logic [4:0] CHEN_ADDR = 5'h02;
    localparam logic [4:0] POL_ADDR  = 5'h03;
    localparam logic [4:0] STAT_ADDR = 5'h04;
    localparam logic [4:0] DUTY_BASE = 5'h10;

    localparam int CTRL_GEN_BIT    = 0;
    localparam int CTRL_CENTER_BIT = 1;
    localparam int CTRL_FORCE_BIT  = 2;

    // Stored CTRL bits; FORCE_UPD is a pulse and is never stored
    typedef struct packed {
        logic center;
        logic gen;
    } pwm_ctrl_t;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, edge/centre-aligned counter and the
// tick/period-start strobes used by every channel.
module pwm_timebase
    import pwm_multi_pkg::*;
#(
    parameter int RES_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gen,
    input  logic             center,
    input  logic             restart,
    input  logic [31:0]      dvsr,
    output logic [RES_W-1:0] cnt,
    output logic             tick,
    output logic             pstart
);

    localparam logic [RES_W-1:0] CNT_MAX  = {RES_W{1'b1}};
    localparam logic [RES_W-1:0] CNT_ONE  = {{(RES_W-1){1'b0}}, 1'b1};
    localparam logic [RES_W-1:0] CNT_ZERO = {RES_W{1'b0}};

    logic [31:0]      q_r;
    logic [RES_W-1:0] cnt_r;
    logic             down_r;
    logic             tick_s;
    logic             pstart_s;

    // Tick and period-start strobes derived from the current state
    always_comb begin
        tick_s   = gen & (q_r == dvsr);
        pstart_s = tick_s & (cnt_r == CNT_ZERO) & (~center | ~down_r);
    end

    // Prescaler and counter; direction flips on the tick that reaches an
    // endpoint so each endpoint is held for exactly one tick
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r    <= 32'd0;
            cnt_r  <= CNT_ZERO;
            down_r <= 1'b0;
        end else if (!gen || restart) begin
            q_r    <= 32'd0;
            cnt_r  <= CNT_ZERO;
            down_r <= 1'b0;
        end else if (tick_s) begin
            q_r <= 32'd0;
            if (!center) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else if (!down_r) begin
                cnt_r <= cnt_r + CNT_ONE;
                if (cnt_r == (CNT_MAX - CNT_ONE)) begin
                    down_r <= 1'b1;
                end
            end else begin
                cnt_r <= cnt_r - CNT_ONE;
                if (cnt_r == CNT_ONE) begin
                    down_r <= 1'b0;
                end
            end
        end else begin
            q_r <= q_r + 32'd1;
        end
    end

    assign cnt    = cnt_r;
    assign tick   = tick_s;
    assign pstart = pstart_s;

endmodule

// File: rtl/pwm_multi_core.sv
// Multi-channel PWM core on the slot bus: double-buffered duty registers,
// edge/centre-aligned timebase, per-channel enable and polarity.
module pwm_multi_core
    import pwm_multi_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int RES_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              read,
    input  logic              write,
    input  logic [4:0]        reg_addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam logic [31:0] DUTY_FULL = 32'd1 << RES_W;
    localparam logic [4:0]  NUM_CH_W  = 5'(NUM_CH);

    logic [31:0]      dvsr_r;
    pwm_ctrl_t        ctrl_r;
    logic [NUM_CH-1:0] chen_r;
    logic [NUM_CH-1:0] pol_r;
    logic             pend_r;
    logic [15:0]      period_r;
    logic [RES_W:0]   shadow_r [NUM_CH];
    logic [RES_W:0]   active_r [NUM_CH];
    logic [NUM_CH-1:0] pwm_out_r;

    logic             wr_s;
    logic             wr_ctrl_s;
    logic             force_s;
    logic             restart_s;
    logic             duty_wr_s;
    logic             duty_in_range_s;
    logic             transfer_s;
    logic [RES_W:0]   duty_sat_s;
    logic [RES_W:0]   duty_rd_s;
    logic [RES_W:0]   shadow_nxt_s [NUM_CH];
    logic [NUM_CH-1:0] raw_s;
    logic [RES_W-1:0] cnt_s;
    logic             pstart_s;
    logic             tick_unused_s;
    logic             read_unused_s;

    // rd_data is a pure address mux, so the read strobe carries no information
    assign read_unused_s = read;

    pwm_timebase #(
        .RES_W (RES_W)
    ) u_timebase (
        .clk     (clk),
        .reset   (reset),
        .gen     (ctrl_r.gen),
        .center  (ctrl_r.center),
        .restart (restart_s),
        .dvsr    (dvsr_r),
        .cnt     (cnt_s),
        .tick    (tick_unused_s),
        .pstart  (pstart_s)
    );

    // Bus write decode and duty saturation
    always_comb begin
        wr_s            = cs & write;
        wr_ctrl_s       = wr_s & (reg_addr == CTRL_ADDR);
        force_s         = wr_ctrl_s & wr_data[CTRL_FORCE_BIT];
        restart_s       = wr_ctrl_s & (wr_data[CTRL_CENTER_BIT] != ctrl_r.center);
        duty_in_range_s = reg_addr[4] & ({1'b0, reg_addr[3:0]} < NUM_CH_W);
        duty_wr_s       = wr_s & duty_in_range_s;
        if (wr_data > DUTY_FULL) begin
            duty_sat_s = DUTY_FULL[RES_W:0];
        end else begin
            duty_sat_s = wr_data[RES_W:0];
        end
        transfer_s = pstart_s | ~ctrl_r.gen | force_s;
    end

    // Next shadow values, so a write in the pstart cycle is transferred too
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            if (duty_wr_s && (reg_addr[3:0] == 4'(n))) begin
                shadow_nxt_s[n] = duty_sat_s;
            end else begin
                shadow_nxt_s[n] = shadow_r[n];
            end
        end
    end

    // Configuration, duty buffers, update-pending flag and period counter
    always_ff @(posedge clk) begin
        if (reset) begin
            dvsr_r   <= 32'd0;
            ctrl_r   <= '{center: 1'b0, gen: 1'b0};
            chen_r   <= {NUM_CH{1'b0}};
            pol_r    <= {NUM_CH{1'b0}};
            pend_r   <= 1'b0;
            period_r <= 16'd0;
            for (int n = 0; n < NUM_CH; n++) begin
                shadow_r[n] <= {(RES_W+1){1'b0}};
                active_r[n] <= {(RES_W+1){1'b0}};
            end
        end else begin
            if (wr_s && (reg_addr == DVSR_ADDR)) begin
                dvsr_r <= wr_data;
            end
            if (wr_ctrl_s) begin
                ctrl_r <= '{center: wr_data[CTRL_CENTER_BIT], gen: wr_data[CTRL_GEN_BIT]};
            end
            if (wr_s && (reg_addr == CHEN_ADDR)) begin
                chen_r <= wr_data[NUM_CH-1:0];
            end
            if (wr_s && (reg_addr == POL_ADDR)) begin
                pol_r <= wr_data[NUM_CH-1:0];
            end
            shadow_r <= shadow_nxt_s;
            if (transfer_s) begin
                active_r <= shadow_nxt_s;
                pend_r   <= 1'b0;
            end else if (duty_wr_s) begin
                pend_r <= 1'b1;
            end
            if (pstart_s) begin
                period_r <= period_r + 16'd1;
            end
        end
    end

    // Per-channel compare against the shared counter
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        assign raw_s[n] = ctrl_r.gen & chen_r[n] & ({1'b0, cnt_s} < active_r[n]);
    end

    // Registered outputs; a disabled channel rests at its polarity level
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_out_r <= {NUM_CH{1'b0}};
        end else begin
            pwm_out_r <= raw_s ^ pol_r;
        end
    end

    assign pwm_out = pwm_out_r;

    // Shadow duty selected by the low address bits
    always_comb begin
        duty_rd_s = {(RES_W+1){1'b0}};
        for (int n = 0; n < NUM_CH; n++) begin
            if (reg_addr[3:0] == 4'(n)) begin
                duty_rd_s = shadow_r[n];
            end else begin
                duty_rd_s = duty_rd_s;
            end
        end
    end

    // Read mux; unmapped addresses and unused bits read 0
    always_comb begin
        rd_data = 32'd0;
        case (reg_addr)
            DVSR_ADDR: rd_data = dvsr_r;
            CTRL_ADDR: rd_data = {30'd0, ctrl_r};
            CHEN_ADDR: rd_data[NUM_CH-1:0] = chen_r;
            POL_ADDR:  rd_data[NUM_CH-1:0] = pol_r;
            STAT_ADDR: rd_data = {period_r, 15'd0, pend_r};
            default: begin
                if (duty_in_range_s) begin
                    rd_data[RES_W:0] = duty_rd_s;
                end else begin
                    rd_data = 32'd0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_multi_core.sv
// Self-checking bench for pwm_multi_core: period-position reference model
// compared every cycle, plus directed literal checks of the main scenarios.
module tb_pwm_multi_core;

    localparam int NUM_CH  = 6;
    localparam int RES_W   = 8;
    localparam int CNT_MAX = 255;
    localparam int FULL    = 256;

    logic              clk;
    logic              reset;
    logic              cs;
    logic              read;
    logic              write;
    logic [4:0]        reg_addr;
    logic [31:0]       wr_data;
    logic [31:0]       rd_data;
    logic [NUM_CH-1:0] pwm_out;

    int n_checks = 0;
    int n_errors = 0;

    pwm_multi_core #(.NUM_CH(NUM_CH), .RES_W(RES_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .read     (read),
        .write    (write),
        .reg_addr (reg_addr),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .pwm_out  (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: position inside the period rather than a counter+direction
    int unsigned       m_dvsr;
    int unsigned       m_wait;
    bit                m_gen, m_center, m_pend, m_valid;
    bit [NUM_CH-1:0]   m_en, m_pol;
    logic [NUM_CH-1:0] m_pwm;
    int                m_sh  [NUM_CH];
    int                m_act [NUM_CH];
    int                m_pos, m_period;

    initial m_valid = 1'b0;

    function automatic int m_level();
        if (m_center) return (m_pos <= CNT_MAX) ? m_pos : 2 * CNT_MAX - m_pos;
        return m_pos;
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        int i;
        logic [15:0] per;
        i = int'(a);
        per = m_period[15:0];
        if (i == 0) return m_dvsr;
        if (i == 1) return {30'd0, m_center, m_gen};
        if (i == 2) return 32'(m_en);
        if (i == 3) return 32'(m_pol);
        if (i == 4) return {per, 15'd0, m_pend};
        if (i >= 16 && i < 16 + NUM_CH) return 32'(m_sh[i-16]);
        return 32'd0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int  lvl, plen, idx;
        bit  tk, pst, wr, duty_wr, xfer;
        int  sh_new [NUM_CH];
        if (reset) begin
            m_dvsr = 0; m_wait = 0; m_gen = 0; m_center = 0; m_pend = 0;
            m_en = '0; m_pol = '0; m_pwm = '0; m_pos = 0; m_period = 0;
            for (int n = 0; n < NUM_CH; n++) begin
                m_sh[n] = 0;
                m_act[n] = 0;
            end
            m_valid = 1'b1;
        end else begin
            lvl = m_level();
            for (int n = 0; n < NUM_CH; n++)
                m_pwm[n] = (m_gen && m_en[n] && (m_act[n] > lvl)) ^ m_pol[n];
            tk  = m_gen && (m_wait == m_dvsr);
            pst = tk && (m_pos == 0);
            wr  = cs && write;
            idx = int'(reg_addr) - 16;
            duty_wr = wr && (idx >= 0) && (idx < NUM_CH);
            sh_new = m_sh;
            if (duty_wr) sh_new[idx] = (wr_data > 32'(FULL)) ? FULL : int'(wr_data);
            xfer = pst || !m_gen || (wr && reg_addr == 5'd1 && wr_data[2]);
            if (xfer) m_act = sh_new;
            m_pend = xfer ? 1'b0 : (duty_wr ? 1'b1 : m_pend);
            m_sh = sh_new;
            if (pst) m_period = (m_period + 1) % 65536;
            plen = m_center ? 2 * CNT_MAX : CNT_MAX + 1;
            if (!m_gen || (wr && reg_addr == 5'd1 && wr_data[1] != m_center)) begin
                m_pos = 0;
                m_wait = 0;
            end else if (tk) begin
                m_wait = 0;
                m_pos = (m_pos + 1) % plen;
            end else begin
                m_wait++;
            end
            if (wr) begin
                case (reg_addr)
                    5'd0: m_dvsr = wr_data;
                    5'd1: begin m_gen = wr_data[0]; m_center = wr_data[1]; end
                    5'd2: m_en = wr_data[NUM_CH-1:0];
                    5'd3: m_pol = wr_data[NUM_CH-1:0];
                    default: ;
                endcase
            end
        end
    end

    // Compare DUT against the model every cycle once reset has been seen
    always @(negedge clk) begin
        #2;
        if (m_valid) begin
            check("pwm_out_model", 32'(pwm_out), 32'(m_pwm));
            check("rd_data_model", rd_data, m_rd(reg_addr));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cs = 1'($urandom); read = 1'($urandom); write = 1'b0;
            reg_addr = 5'($urandom); wr_data = $urandom;
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; read = 1'b0; reg_addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic rd_check(input string nm, input logic [4:0] a, input logic [31:0] mask,
                            input logic [31:0] exp);
        @(negedge clk);
        cs = 1'b1; read = 1'b1; write = 1'b0; reg_addr = a;
        #3;
        check(nm, rd_data & mask, exp);
    endtask

    task automatic wait_level(input string nm, input int ch, input logic lvl, input int limit);
        for (int k = 0; k < limit; k++) begin
            @(negedge clk); #3;
            if (pwm_out[ch] === lvl) return;
        end
        check(nm, 32'(pwm_out[ch]), 32'(lvl));
    endtask

    task automatic count_run(input int ch, input logic lvl, input int limit, output int len);
        len = 1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk); #3;
            if (pwm_out[ch] !== lvl) return;
            len++;
        end
    endtask

    initial begin : stim
        int len, ok;
        reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; reg_addr = 5'd0; wr_data = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        rd_check("rst_dvsr",   5'h00, 32'hFFFF_FFFF, 32'd0);
        rd_check("rst_ctrl",   5'h01, 32'hFFFF_FFFF, 32'd0);
        rd_check("rst_chen",   5'h02, 32'hFFFF_FFFF, 32'd0);
        rd_check("rst_pol",    5'h03, 32'hFFFF_FFFF, 32'd0);
        rd_check("rst_status", 5'h04, 32'hFFFF_FFFF, 32'd0);
        rd_check("rst_duty0",  5'h10, 32'hFFFF_FFFF, 32'd0);
        ok = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #3;
            if (pwm_out == '0) ok++;
        end
        check("rst_pwm_low_5clk", 32'(ok), 32'd5);

        // Edge mode, duty 64
        bus_write(5'h02, 32'd1);
        bus_write(5'h10, 32'd64);
        bus_write(5'h01, 32'd1);
        #3;
        check("edge_before_rise", 32'(pwm_out[0]), 32'd0);
        @(negedge clk); #3;
        check("edge_first_rise", 32'(pwm_out[0]), 32'd1);
        count_run(0, 1'b1, 600, len);
        check("edge_high_64", 32'(len), 32'd64);
        count_run(0, 1'b0, 600, len);
        check("edge_low_192", 32'(len), 32'd192);

        // Mid-period duty update takes effect at the next boundary
        bus_write(5'h10, 32'd128);
        rd_check("upd_pend_set", 5'h04, 32'd1, 32'd1);
        count_run(0, 1'b1, 600, len);
        check("old_duty_rest_61", 32'(len), 32'd61);
        rd_check("upd_pend_held", 5'h04, 32'd1, 32'd1);
        count_run(0, 1'b0, 600, len);
        check("old_low_191", 32'(len), 32'd191);
        count_run(0, 1'b1, 600, len);
        check("new_high_128", 32'(len), 32'd128);
        rd_check("upd_pend_clr", 5'h04, 32'd1, 32'd0);

        // Centre mode, duty 64: cnt<64 on both slopes around cnt==0
        bus_write(5'h10, 32'd64);
        bus_write(5'h01, 32'd7);
        wait_level("center_wait_low", 0, 1'b0, 600);
        wait_level("center_wait_high", 0, 1'b1, 600);
        count_run(0, 1'b1, 600, len);
        check("center_high_127", 32'(len), 32'd127);
        count_run(0, 1'b0, 600, len);
        check("center_low_383", 32'(len), 32'd383);

        // Duty extremes with polarity and channel enable
        bus_write(5'h01, 32'd1);
        bus_write(5'h11, 32'd0);
        bus_write(5'h12, 32'd256);
        bus_write(5'h03, 32'h2);
        bus_write(5'h02, 32'h7);
        bus_write(5'h01, 32'd5);
        idle(2);
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #3;
            if (pwm_out[1] === 1'b1 && pwm_out[2] === 1'b1) ok++;
        end
        check("ch1_inv0_ch2_full_high", 32'(ok), 32'd300);
        bus_write(5'h02, 32'h3);
        idle(2);
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #3;
            if (pwm_out[2] === 1'b0 && pwm_out[1] === 1'b1) ok++;
        end
        check("ch2_disabled_low", 32'(ok), 32'd20);

        // Reset mid-period with a prescaler
        bus_write(5'h00, 32'd3);
        idle(100);
        @(negedge clk);
        reset = 1'b1; cs = 1'b0; write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #3;
        check("midrst_pwm", 32'(pwm_out), 32'd0);
        rd_check("midrst_status", 5'h04, 32'hFFFF_FFFF, 32'd0);
        rd_check("midrst_dvsr", 5'h00, 32'hFFFF_FFFF, 32'd0);

        // Randomized traffic, checked by the model
        for (int it = 0; it < 45; it++) begin
            int op;
            bit f, c, g;
            op = $urandom_range(0, 10);
            f = ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 3) == 0);
            g = ($urandom_range(0, 5) != 0);
            case (op)
                0:       bus_write(5'h00, 32'($urandom_range(0, 3)));
                1, 2:    bus_write(5'h01, {29'd0, f, c, g});
                3:       bus_write(5'h02, $urandom);
                4:       bus_write(5'h03, $urandom);
                5, 6, 7: bus_write(5'(16 + $urandom_range(0, 7)), 32'($urandom_range(0, 300)));
                8:       bus_write(5'(16 + $urandom_range(0, 15)), $urandom);
                9: begin
                    @(negedge clk); reset = 1'b1;
                    @(negedge clk); reset = 1'b0;
                end
                default: bus_write(5'($urandom_range(4, 31)), $urandom);
            endcase
            idle($urandom_range(1, 700));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
